// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered one-hot grant and hold-limit preemption
module rr_onehot_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic                       gnt_valid_o,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic [0:0]         state, state_n;
   logic [IW-1:0]      ptr, ptr_n;
   logic [HW-1:0]      hold_cnt, hold_n;
   logic [NUM_REQ-1:0] grant_n;
   logic [IW-1:0]      id_n;
   logic [IW-1:0]      rel_next;
   logic [NUM_REQ-1:0] others;

   // First set bit of cand, scanning start, start+1, ... with wrap; caller guarantees cand != 0.
   function automatic logic [IW-1:0] search(input logic [NUM_REQ-1:0] cand,
                                            input logic [IW-1:0]      start);
      logic          found;
      logic [IW-1:0] idx;
      int            j;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(start) + i) % NUM_REQ;
         if (!found && cand[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
      return idx;
   endfunction

   assign rel_next = IW'((int'(gnt_id_o) + 1) % NUM_REQ);
   assign others   = req_i & ~grant_o;

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      grant_n = grant_o;
      id_n    = gnt_id_o;
      case (state)
         ST_IDLE: begin
            if (|req_i) begin
               id_n    = search(req_i, ptr);
               grant_n = ONE << id_n;
               hold_n  = HW'(1);
               state_n = ST_GRANT;
            end
         end
         default: begin
            if (!req_i[gnt_id_o]) begin
               ptr_n = rel_next;
               if (|others) begin
                  id_n    = search(others, rel_next);
                  grant_n = ONE << id_n;
                  hold_n  = HW'(1);
               end else begin
                  grant_n = '0;
                  id_n    = '0;
                  state_n = ST_IDLE;
               end
            end else if (MAX_HOLD != 0 && int'(hold_cnt) == MAX_HOLD && |others) begin
               // others already excludes the current owner, so it cannot win again here.
               ptr_n   = rel_next;
               id_n    = search(others, rel_next);
               grant_n = ONE << id_n;
               hold_n  = HW'(1);
            end else if (int'(hold_cnt) < MAX_HOLD) begin
               hold_n = hold_cnt + HW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant_o     <= '0;
         gnt_valid_o <= 1'b0;
         gnt_id_o    <= '0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         hold_cnt    <= hold_n;
         grant_o     <= grant_n;
         gnt_valid_o <= |grant_n;
         gnt_id_o    <= id_n;
      end
   end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - scoreboard bench for rr_onehot_arbiter (NUM_REQ=4, MAX_HOLD=4)
module tb_rr_onehot_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       valid;
   logic [1:0] id;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];

   rr_onehot_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req),
      .grant_o    (grant),
      .gnt_valid_o(valid),
      .gnt_id_o   (id)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int b = 0; b < 4; b++) if (g[b]) r = 2'(b);
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] rst_tab[3] = '{4'b1111, 4'b1111, 4'b1111};
      logic       rs_tab[3]  = '{1'b1, 1'b1, 1'b0};
      logic [3:0] exp_tab[3] = '{4'b0000, 4'b0000, 4'b0001};
      logic [3:0] e;
      for (int i = 0; i < 3; i++) begin
         reset = rs_tab[i];
         req   = rst_tab[i];
         exp_q.push_back(exp_tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++; if (grant !== e) begin errors++; $display("FAIL reset step %0d grant %b expected %b", i, grant, e); end
         checks++; if (valid !== (|e)) begin errors++; $display("FAIL reset step %0d valid %b expected %b", i, valid, |e); end
         checks++; if (id !== idx_of(e)) begin errors++; $display("FAIL reset step %0d id %0d expected %0d", i, id, idx_of(e)); end
      end
   endtask

   task automatic test_single();
      logic [3:0] e;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req = (i < 3) ? 4'b0001 : 4'b0000;
         exp_q.push_back((i < 3) ? 4'b0001 : 4'b0000);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++; if (grant !== e) begin errors++; $display("FAIL single step %0d grant %b expected %b", i, grant, e); end
         checks++; if (valid !== (|e)) begin errors++; $display("FAIL single step %0d valid %b expected %b", i, valid, |e); end
      end
   endtask

   task automatic test_rotation();
      logic [3:0] e;
      logic [3:0] one;
      one = 4'b0001;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         req = 4'b1111;
         exp_q.push_back(one << ((i / 4) % 4));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++; if (grant !== e) begin errors++; $display("FAIL rotation step %0d grant %b expected %b", i, grant, e); end
         checks++; if (id !== idx_of(e)) begin errors++; $display("FAIL rotation step %0d id %0d expected %0d", i, id, idx_of(e)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] req_tab[5] = '{4'b0100, 4'b1011, 4'b1011, 4'b0011, 4'b0000};
      logic [3:0] exp_tab[5] = '{4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
      logic [3:0] e;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req = req_tab[i];
         exp_q.push_back(exp_tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++; if (grant !== e) begin errors++; $display("FAIL handoff step %0d grant %b expected %b", i, grant, e); end
         checks++; if (id !== idx_of(e)) begin errors++; $display("FAIL handoff step %0d id %0d expected %0d", i, id, idx_of(e)); end
      end
   endtask

   task automatic test_sole();
      logic [3:0] e;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         // The extra requester on step 10 must preempt at once if hold_cnt saturated at the limit.
         req = (i < 10) ? 4'b0100 : 4'b0110;
         exp_q.push_back((i < 10) ? 4'b0100 : 4'b0010);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++; if (grant !== e) begin errors++; $display("FAIL sole step %0d grant %b expected %b", i, grant, e); end
         checks++; if (id !== idx_of(e)) begin errors++; $display("FAIL sole step %0d id %0d expected %0d", i, id, idx_of(e)); end
      end
   endtask

   task automatic test_reset_mid();
      logic       rs_tab[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] req_tab[4] = '{4'b0100, 4'b0010, 4'b1010, 4'b1010};
      logic [3:0] exp_tab[4] = '{4'b0100, 4'b0010, 4'b0000, 4'b0010};
      logic [3:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         reset = rs_tab[i];
         req   = req_tab[i];
         exp_q.push_back(exp_tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++; if (grant !== e) begin errors++; $display("FAIL reset_mid step %0d grant %b expected %b", i, grant, e); end
         checks++; if (valid !== (|e)) begin errors++; $display("FAIL reset_mid step %0d valid %b expected %b", i, valid, |e); end
         checks++; if (id !== idx_of(e)) begin errors++; $display("FAIL reset_mid step %0d id %0d expected %0d", i, id, idx_of(e)); end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      test_reset();
      test_single();
      test_rotation();
      test_back_to_back();
      test_sole();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
